// File: rtl/irq_vector_sequencer.sv
// 6502 interrupt/reset entry sequencer: stacks PC and P, fetches the vector
// and hands the new PC to the datapath.
module irq_vector_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] RST_VEC    = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        boundary,
    input  logic        brk,
    input  logic        nmi,
    input  logic        irq,
    input  logic [15:0] pc,
    input  logic [7:0]  p,
    input  logic [7:0]  sp,
    input  logic [7:0]  data_read,
    output logic [15:0] address,
    output logic [7:0]  data_write,
    output logic        read_write_sel,
    output logic        sp_dec,
    output logic        pc_load,
    output logic [15:0] pc_new,
    output logic        i_set,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, RST_PCH, RST_PCL, RST_P,
        PUSH_PCH, PUSH_PCL, PUSH_P,
        FETCH_LO, FETCH_HI, LOAD
    } state_t;

    state_t      state;
    logic        nmi_q;
    logic        nmi_pend;
    logic        is_nmi;
    logic        b_flag;
    logic [15:0] vec;
    logic [15:0] pc_new_q;
    logic        nmi_edge;
    logic        nmi_seen;
    logic        take_nmi;

    assign nmi_edge = nmi & ~nmi_q;
    assign nmi_seen = nmi_pend | nmi_edge;
    // leaving PUSH_P for FETCH_LO as an NMI sequence consumes the request
    assign take_nmi = (state == PUSH_P) & (is_nmi | nmi_seen);
    assign pc_new   = reset ? 16'h0000 : pc_new_q;

    always_ff @(posedge ph1) begin
        nmi_q <= nmi;
        if (reset) begin
            state    <= RST_PCH;
            nmi_pend <= 1'b0;
            is_nmi   <= 1'b0;
            b_flag   <= 1'b0;
            vec      <= RST_VEC;
            pc_new_q <= 16'h0000;
        end else begin
            nmi_pend <= take_nmi ? 1'b0 : nmi_seen;
            unique case (state)
                IDLE: begin
                    if (boundary) begin
                        if (nmi_pend) begin
                            state  <= PUSH_PCH;
                            vec    <= NMI_VEC;
                            is_nmi <= 1'b1;
                            b_flag <= 1'b0;
                        end else if (brk) begin
                            state  <= PUSH_PCH;
                            vec    <= IRQ_VEC;
                            is_nmi <= 1'b0;
                            b_flag <= 1'b1;
                        end else if (irq & ~p[2]) begin
                            state  <= PUSH_PCH;
                            vec    <= IRQ_VEC;
                            is_nmi <= 1'b0;
                            b_flag <= 1'b0;
                        end
                    end
                end
                RST_PCH: state <= RST_PCL;
                RST_PCL: state <= RST_P;
                RST_P:   state <= FETCH_LO;
                PUSH_PCH, PUSH_PCL, PUSH_P: begin
                    unique case (state)
                        PUSH_PCH: state <= PUSH_PCL;
                        PUSH_PCL: state <= PUSH_P;
                        default:  state <= FETCH_LO;
                    endcase
                    // a late NMI steals the vector; stacked B bit is kept
                    if (nmi_seen) begin
                        vec    <= NMI_VEC;
                        is_nmi <= 1'b1;
                    end
                end
                FETCH_LO: begin
                    pc_new_q[7:0] <= data_read;
                    state         <= FETCH_HI;
                end
                FETCH_HI: begin
                    pc_new_q[15:8] <= data_read;
                    state          <= LOAD;
                end
                LOAD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        address        = 16'h0000;
        data_write     = 8'h00;
        read_write_sel = 1'b1;
        sp_dec         = 1'b0;
        pc_load        = 1'b0;
        i_set          = 1'b0;
        busy           = 1'b1;
        if (!reset) begin
            unique case (state)
                IDLE: busy = 1'b0;
                RST_PCH, RST_PCL, RST_P: begin
                    address = {STACK_PAGE, sp};
                    sp_dec  = 1'b1;
                end
                PUSH_PCH: begin
                    address        = {STACK_PAGE, sp};
                    data_write     = pc[15:8];
                    read_write_sel = 1'b0;
                    sp_dec         = 1'b1;
                end
                PUSH_PCL: begin
                    address        = {STACK_PAGE, sp};
                    data_write     = pc[7:0];
                    read_write_sel = 1'b0;
                    sp_dec         = 1'b1;
                end
                PUSH_P: begin
                    address        = {STACK_PAGE, sp};
                    data_write     = {p[7:6], 1'b1, b_flag, p[3:0]};
                    read_write_sel = 1'b0;
                    sp_dec         = 1'b1;
                end
                FETCH_LO: address = vec;
                FETCH_HI: address = vec + 16'd1;
                LOAD: begin
                    pc_load = 1'b1;
                    i_set   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// Scoreboard bench for irq_vector_sequencer: expected bus cycles are queued
// at sequence start and a negedge monitor checks every DUT cycle.
module tb_irq_vector_sequencer;

    logic        ph1 = 1'b0;
    logic        reset, boundary, brk, nmi, irq;
    logic [15:0] pc;
    logic [7:0]  p, sp, data_read;
    logic [15:0] address, pc_new;
    logic [7:0]  data_write;
    logic        read_write_sel, sp_dec, pc_load, i_set, busy;

    logic [7:0]  sp_base;
    logic [7:0]  sp_cnt = 8'h00;
    logic [7:0]  vrom [8];

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wd;
        logic        spd;
        logic        ld;
        logic [15:0] pcn;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    irq_vector_sequencer dut (
        .ph1(ph1), .reset(reset), .boundary(boundary), .brk(brk),
        .nmi(nmi), .irq(irq), .pc(pc), .p(p), .sp(sp),
        .data_read(data_read), .address(address),
        .data_write(data_write), .read_write_sel(read_write_sel),
        .sp_dec(sp_dec), .pc_load(pc_load), .pc_new(pc_new),
        .i_set(i_set), .busy(busy)
    );

    initial forever #5 ph1 = ~ph1;

    // datapath model: stack pointer decrements when asked
    always @(posedge ph1) if (sp_dec === 1'b1) sp_cnt <= sp_cnt + 8'd1;
    assign sp = sp_base - sp_cnt;

    // memory model: vectors at FFFA..FFFF, filler pattern elsewhere
    always_comb begin
        data_read = address[7:0] ^ address[15:8] ^ 8'h5A;
        if (address >= 16'hFFFA) data_read = vrom[address[2:0]];
    end

    function automatic logic [7:0] rom_rd(input logic [15:0] a);
        return vrom[a[2:0]];
    endfunction

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    // kind: 0 reset, 1 nmi, 2 irq, 3 brk
    task automatic push_seq(input int kind, input bit hij,
                            input logic [7:0] s0, input logic [15:0] pcv,
                            input logic [7:0] pv);
        exp_t        e;
        logic [15:0] v;
        logic [7:0]  sa;
        logic [7:0]  pb;
        v  = (kind == 0) ? 16'hFFFC :
             ((kind == 1) || hij) ? 16'hFFFA : 16'hFFFE;
        sa = s0;
        pb = pv | 8'h20;
        pb[4] = (kind == 3);
        for (int i = 0; i < 3; i++) begin
            e.addr = {8'h01, sa};
            e.rw   = (kind == 0);
            e.wd   = (i == 0) ? pcv[15:8] : (i == 1) ? pcv[7:0] : pb;
            e.spd  = 1'b1;
            e.ld   = 1'b0;
            e.pcn  = 16'h0000;
            q.push_back(e);
            sa = sa - 8'd1;
        end
        for (int i = 0; i < 2; i++) begin
            e.addr = v + 16'(i);
            e.rw   = 1'b1;
            e.wd   = 8'h00;
            e.spd  = 1'b0;
            q.push_back(e);
        end
        e.addr = 16'h0000;
        e.ld   = 1'b1;
        e.pcn  = {rom_rd(v + 16'd1), rom_rd(v)};
        q.push_back(e);
    endtask

    always @(negedge ph1) begin
        exp_t e;
        if (reset === 1'b1) begin
            checks++;
            if (busy !== 1'b1 || address !== 16'h0 || data_write !== 8'h0 ||
                read_write_sel !== 1'b1 || sp_dec !== 1'b0 ||
                pc_load !== 1'b0 || i_set !== 1'b0 || pc_new !== 16'h0) begin
                errors++;
                $display("FAIL reset_state: busy=%b addr=%h wd=%h rw=%b spd=%b ld=%b is=%b pcn=%h, want 1 0000 00 1 0 0 0 0000",
                         busy, address, data_write, read_write_sel, sp_dec,
                         pc_load, i_set, pc_new);
            end
        end else if (busy === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_busy: addr=%h rw=%b, want busy=0",
                         address, read_write_sel);
            end else begin
                e = q.pop_front();
                if (address !== e.addr || read_write_sel !== e.rw ||
                    (!e.rw && data_write !== e.wd) || sp_dec !== e.spd ||
                    pc_load !== e.ld || i_set !== e.ld ||
                    (e.ld && pc_new !== e.pcn)) begin
                    errors++;
                    $display("FAIL bus_cycle: got addr=%h rw=%b wd=%h spd=%b ld=%b is=%b pcn=%h, want addr=%h rw=%b wd=%h spd=%b ld=%b pcn=%h",
                             address, read_write_sel, data_write, sp_dec,
                             pc_load, i_set, pc_new, e.addr, e.rw, e.wd,
                             e.spd, e.ld, e.pcn);
                end
            end
        end else begin
            checks++;
            if (busy !== 1'b0 || address !== 16'h0 || read_write_sel !== 1'b1 ||
                sp_dec !== 1'b0 || pc_load !== 1'b0 || i_set !== 1'b0) begin
                errors++;
                $display("FAIL idle_bus: busy=%b addr=%h rw=%b spd=%b ld=%b is=%b, want 0 0000 1 0 0 0",
                         busy, address, read_write_sel, sp_dec, pc_load, i_set);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 12) begin
            step();
            n++;
        end
        checks++;
        if (n >= 12) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d expected cycles not seen, want 0", name, q.size());
        end
    endtask

    task automatic run_seq(input bit want_nmi, input bit do_brk,
                           input bit do_irq, input logic [15:0] pcv,
                           input logic [7:0] pv, input logic [7:0] spv,
                           input int hij_k);
        int kind;
        if (want_nmi || hij_k >= 0) begin
            nmi = 1'b0;
            step();
        end
        if (want_nmi) begin
            nmi = 1'b1;
            step();
        end
        kind = want_nmi ? 1 : do_brk ? 3 : (do_irq && !pv[2]) ? 2 : -1;
        pc       = pcv;
        p        = pv;
        sp_base  = spv + sp_cnt;
        brk      = do_brk;
        irq      = do_irq;
        boundary = 1'b1;
        if (kind >= 0) push_seq(kind, (hij_k >= 0 && kind != 1), spv, pcv, pv);
        step();
        boundary = 1'b0;
        brk      = 1'b0;
        if (kind < 0) begin
            repeat (3) begin
                boundary = 1'b1;
                step();
                boundary = 1'b0;
                step();
            end
            irq = 1'b0;
            wait_idle("masked");
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (i == hij_k && kind != 1) nmi = 1'b1;
                irq = 1'($urandom % 2);
                if (i < 4) begin
                    boundary = 1'($urandom % 2);
                    brk      = 1'($urandom % 2);
                end else begin
                    boundary = 1'b0;
                    brk      = 1'b0;
                end
                step();
            end
            wait_idle("seq");
            irq = 1'b0;
            step();
        end
    endtask

    task automatic nmi_reset_abort();
        nmi = 1'b0;
        step();
        nmi = 1'b1;
        step();
        pc       = 16'hBEEF;
        p        = 8'h81;
        sp_base  = 8'h40 + sp_cnt;
        boundary = 1'b1;
        push_seq(1, 1'b0, 8'h40, 16'hBEEF, 8'h81);
        step();
        boundary = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        q.delete();
        step();
        vrom[4] = 8'h3C;
        vrom[5] = 8'hA7;
        push_seq(0, 1'b0, sp, 16'h0000, 8'h00);
        reset = 1'b0;
        wait_idle("abort");
        step();
    endtask

    initial begin
        int          r;
        int          hk;
        logic [7:0]  pv;
        logic [7:0]  spv;
        reset    = 1'b1;
        boundary = 1'b0;
        brk      = 1'b0;
        nmi      = 1'b0;
        irq      = 1'b0;
        pc       = 16'h0000;
        p        = 8'h00;
        sp_base  = 8'hFD;
        for (int j = 0; j < 8; j++) vrom[j] = 8'($urandom);
        vrom[4] = 8'h00;
        vrom[5] = 8'hF0;
        @(posedge ph1);
        @(posedge ph1);
        #1;
        push_seq(0, 1'b0, 8'hFD, 16'h0000, 8'h00);
        reset = 1'b0;
        wait_idle("reset");
        step();

        run_seq(1'b0, 1'b0, 1'b1, 16'h1234, 8'h00, 8'hFF, -1);
        run_seq(1'b0, 1'b1, 1'b0, 16'h4321, 8'h04, 8'h80, -1);
        run_seq(1'b0, 1'b0, 1'b1, 16'h5555, 8'h04, 8'h70, -1);
        run_seq(1'b0, 1'b0, 1'b1, 16'hC0DE, 8'h00, 8'hF0, 1);
        run_seq(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hF0, -1);
        nmi_reset_abort();

        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < 8; j++) vrom[j] = 8'($urandom);
            r   = int'($urandom % 4);
            pv  = 8'($urandom);
            if (r == 2) pv[2] = 1'b0;
            if (r == 3) pv[2] = 1'b1;
            spv = ($urandom % 4 == 0) ? 8'($urandom % 3) : 8'($urandom);
            hk  = ((r == 1 || r == 2) && ($urandom % 3 == 0)) ?
                  int'($urandom % 2) : -1;
            run_seq(r == 0, r == 1, (r >= 2) || ($urandom % 2 == 1),
                    16'($urandom), pv, spv, hk);
        end

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_vector_sequencer.md
Name: irq_vector_sequencer

Overview:
- Sequences the 6502 datapath through reset, NMI, IRQ and BRK entry.
- Takes over the address and data buses from the microcode.
- Pushes PCH, PCL and P to the stack, fetches the 16-bit vector and loads it into the PC.
- Sits between the interrupt pins and the datapath; the microcode hands control to it at instruction boundaries.

Parameters:
STACK_PAGE, 8'h01, high address byte for stack accesses
NMI_VEC, 16'hFFFA, NMI vector low-byte address
RST_VEC, 16'hFFFC, reset vector low-byte address
IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
ph1  in  1  single system clock; all state updates on rising edge
reset  in  1  synchronous, active-high
boundary  in  1  microcode at instruction boundary; sequencer may start
brk  in  1  BRK opcode decoded, valid with boundary
nmi  in  1  NMI request, active-high, edge-sensitive
irq  in  1  IRQ request, active-high, level-sensitive
pc  in  16  current program counter (return address to push)
p  in  8  current status register
sp  in  8  current stack pointer
data_read  in  8  memory read data, valid same cycle as address
address  out  16  bus address while busy, else 16'h0000
data_write  out  8  bus write data
read_write_sel  out  1  1=read, 0=write
sp_dec  out  1  datapath decrements SP at end of this cycle
pc_load  out  1  one-cycle pulse; datapath loads pc_new
pc_new  out  16  vector fetched from memory
i_set  out  1  one-cycle pulse with pc_load; datapath sets P[2]
busy  out  1  sequencer owns the bus

Behaviour:
- Reset values: address=0, data_write=0, read_write_sel=1, sp_dec=0, pc_load=0, pc_new=0, i_set=0, busy=1.
- Reset leaves the FSM in RST_PCH, so a reset sequence always follows reset release.
- Reset asserted mid-sequence aborts the sequence at the next edge and restarts it from RST_PCH.
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, FETCH_LO, FETCH_HI, LOAD. Reset path uses RST_PCH, RST_PCL, RST_P (dummy stack reads).
- NMI edge detect: nmi_q registers nmi every cycle. nmi_pend sets when nmi & ~nmi_q and clears on entry to FETCH_LO of an NMI sequence. An edge arriving while busy stays pending.
- IDLE: busy=0. At boundary, select the source by priority: NMI (nmi_pend) > BRK > IRQ (irq & ~p[2]). Go to PUSH_PCH if any source is selected, else stay in IDLE. The vector is latched at selection.
- PUSH_PCH: address={STACK_PAGE,sp}, data_write=pc[15:8], rw=0, sp_dec=1.
- PUSH_PCL: as PUSH_PCH with pc[7:0].
- PUSH_P: data_write = p | 8'h20, with bit4=1 for BRK and 0 for NMI/IRQ; rw=0, sp_dec=1.
- RST_PCH, RST_PCL, RST_P: same addresses as the push states, rw=1, sp_dec=1, no writes.
- FETCH_LO: address=vec, rw=1, pc_new[7:0] <= data_read.
- FETCH_HI: address=vec+1, rw=1, pc_new[15:8] <= data_read.
- LOAD: pc_load=1, i_set=1, busy=1, rw=1, address=0. Next state is IDLE.
- Sequence length: 6 busy cycles from the state after IDLE through LOAD; pc_load is asserted in the 6th.
- sp is sampled combinationally each cycle. The datapath's decrement makes successive pushes hit sp, sp-1, sp-2. Wrap 8'h00 -> 8'hFF is the datapath's responsibility. Addresses 01FF, 01FE, 01FD are legal.
- vec+1 uses 16-bit addition; FFFF+1 never occurs with the default vectors.
- NMI hijack: if nmi_pend sets during PUSH_PCH..PUSH_P of a BRK/IRQ sequence, the vector switches to NMI_VEC. The pushed B bit keeps the original source's value.
- IRQ is sampled only at selection. Deassertion mid-sequence has no effect.
- boundary is ignored while busy.

Test Plan:
1. Reset held 2 cycles, then released; ROM FFFC=00, FFFD=F0 -> 3 reads at 01FD/01FC/01FB (sp=FD, decrementing), then reads of FFFC and FFFD; pc_load with pc_new=16'hF000, i_set=1; busy drops the next cycle.
2. IDLE, p=8'h00, irq=1, boundary=1, pc=16'h1234, sp=8'hFF -> writes 12@01FF, 34@01FE, 20@01FD; fetch FFFE/FFFF; pc_load on 6th cycle.
3. brk=1 with boundary, p=8'h04 -> BRK taken despite I=1; pushed P = 8'h34; vector FFFE.
4. irq=1 with p[2]=1, boundary pulses -> no sequence; busy stays 0, rw=1.
5. nmi rising edge during PUSH_PCL of an IRQ sequence -> reads FFFA/FFFB; pushed P bit4=0; nmi_pend cleared; nmi held high afterwards triggers no second NMI.
6. reset asserted during FETCH_LO of an NMI sequence -> next cycle in RST_PCH with no writes; reset vector fetched; pc_new comes from FFFC/FFFD.
